// File: rtl/fft_seq.sv
// rtl/fft_seq.sv - frame sequencer for the streaming radix-2 FFT pipeline
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   start, stop           run control; cfg_frames latched on accepted start (0 = unlimited)
//   in_valid / in_ready   source beat handshake; in_ready depends on state only
//   s0_en                 stage-0 enable
//   out_en                final-stage beat valid (s0_en delayed LAT cycles)
//   out_first, out_last   output frame boundary flags, qualified by out_en
//   busy, done            run active / one-cycle end-of-run pulse
//   frame_cnt             completed output frames this run
//   err_underrun          sticky: beat clocked in while in_valid was low
module fft_seq #(
  parameter int N   = 8,
  parameter int LAT = 4,
  parameter int GAP = 0,
  parameter int FW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [FW-1:0] cfg_frames,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          s0_en,
  output logic          out_en,
  output logic          out_first,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [FW-1:0] frame_cnt,
  output logic          err_underrun
);

  localparam int H      = N / 2;
  localparam int BW     = (H > 1) ? $clog2(H) : 1;
  // worst-case frames resident in the pipeline at once
  localparam int IF_MAX = (LAT + H - 1) / H + 1;
  localparam int IFW    = $clog2(IF_MAX + 1);
  localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [BW-1:0] BEAT_LAST = BW'(H - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_GAP   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [BW-1:0]    beat;
  logic [BW-1:0]    obeat;
  logic [GW-1:0]    gap_cnt;
  logic [FW-1:0]    sent;
  logic [FW-1:0]    cfg_l;
  logic [IFW-1:0]   inflight;
  logic             stop_l;
  logic [LAT-1:0]   pipe;

  logic             accept;
  logic             beat_end;
  logic             run_end;
  logic             last_out;

  assign accept   = (state == S_IDLE) && start;
  assign beat_end = (state == S_LOAD) && (beat == BEAT_LAST);
  // a stop arriving on the final beat itself still ends the run at this boundary
  assign run_end  = stop_l || stop ||
                    ((cfg_l != '0) && (FW'(sent + 1'b1) == cfg_l));
  assign last_out = (state == S_DRAIN) && out_last && (inflight == IFW'(1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        if (beat_end) begin
          if (run_end)      state_nx = S_DRAIN;
          else if (GAP > 0) state_nx = S_GAP;
          else              state_nx = S_LOAD;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = S_LOAD;
      end
      S_DRAIN: begin
        if (last_out) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // state-decoded outputs; the pipeline never stalls, so ready ignores in_valid
  always_comb begin
    s0_en    = (state == S_LOAD);
    in_ready = (state == S_LOAD);
    busy     = (state != S_IDLE);
  end

  // run bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      beat         <= '0;
      gap_cnt      <= '0;
      sent         <= '0;
      cfg_l        <= '0;
      inflight     <= '0;
      stop_l       <= 1'b0;
      frame_cnt    <= '0;
      err_underrun <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= last_out;
      if (accept) begin
        beat         <= '0;
        gap_cnt      <= '0;
        sent         <= '0;
        cfg_l        <= cfg_frames;
        inflight     <= '0;
        stop_l       <= stop;
        frame_cnt    <= '0;
        err_underrun <= 1'b0;
      end else begin
        if ((state != S_IDLE) && stop) stop_l <= 1'b1;

        if (state == S_LOAD) begin
          beat <= beat_end ? '0 : beat + 1'b1;
          if (!in_valid) err_underrun <= 1'b1;
          if (beat_end) sent <= sent + 1'b1;
        end

        if (state == S_GAP) gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
        else                gap_cnt <= '0;

        // a frame can enter and another leave in the same cycle
        case ({beat_end, out_last})
          2'b10:   inflight <= inflight + 1'b1;
          2'b01:   inflight <= inflight - 1'b1;
          default: inflight <= inflight;
        endcase

        if (out_last) frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // enable delay line mirroring the latency of the downstream stages
  generate
    if (LAT == 1) begin : g_pipe1
      always_ff @(posedge clk) begin
        if (rst) pipe <= '0;
        else     pipe <= s0_en;
      end
    end else begin : g_pipen
      always_ff @(posedge clk) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[LAT-2:0], s0_en};
      end
    end
  endgenerate

  assign out_en = pipe[LAT-1];

  // output beat position within the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      obeat <= '0;
    end else if (out_en) begin
      obeat <= (obeat == BEAT_LAST) ? '0 : obeat + 1'b1;
    end
  end

  assign out_first = out_en && (obeat == '0);
  assign out_last  = out_en && (obeat == BEAT_LAST);

endmodule

// File: tb/tb_fft_seq.sv
// tb/tb_fft_seq.sv - scoreboard bench for fft_seq (GAP=0 and GAP=2 instances)
module tb_fft_seq;

  localparam int N   = 8;
  localparam int H   = N / 2;
  localparam int LAT = 4;
  localparam int FW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [FW-1:0] cfg_frames;
  logic          in_valid;

  logic          ir0, s0e0, oe0, of0, ol0, busy0, done0, err0;
  logic [FW-1:0] fc0;
  logic          ir2, s0e2, oe2, of2, ol2, busy2, done2, err2;
  logic [FW-1:0] fc2;

  fft_seq #(.N(N), .LAT(LAT), .GAP(0), .FW(FW)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_frames(cfg_frames),
    .in_valid(in_valid), .in_ready(ir0), .s0_en(s0e0), .out_en(oe0),
    .out_first(of0), .out_last(ol0), .busy(busy0), .done(done0),
    .frame_cnt(fc0), .err_underrun(err0)
  );

  fft_seq #(.N(N), .LAT(LAT), .GAP(2), .FW(FW)) u2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_frames(cfg_frames),
    .in_valid(in_valid), .in_ready(ir2), .s0_en(s0e2), .out_en(oe2),
    .out_first(of2), .out_last(ol2), .busy(busy2), .done(done2),
    .frame_cnt(fc2), .err_underrun(err2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
  endtask

  typedef struct { int c; int first; int last; } beat_t;
  typedef struct { int c; int fc; int err; } done_t;

  beat_t bq0[$], bq2[$];
  done_t dq0[$], dq2[$];

  // Reference: frame k occupies s0_en cycles b..b+H-1, next frame starts GAP
  // cycles after; the run ends after the first frame whose last beat is at or
  // after a stop (seen since start) or that reaches the configured count.
  task automatic model(input int s, input int cfg, input int stop_c, input int bad_c,
                       input int gap, input int lim, output int d);
    int b, e, frames, err;
    bit fin;
    beat_t bt;
    done_t dn;
    b = s + 1; e = b; frames = 0; err = 0; fin = 0;
    for (int k = 0; k < 64 && !fin; k++) begin
      e = b + H - 1;
      for (int j = 0; j < H; j++) begin
        if (b + j == bad_c) err = 1;
        bt.c = b + j + LAT; bt.first = (j == 0); bt.last = (j == H - 1);
        if (bt.c <= lim) begin
          if (gap == 0) bq0.push_back(bt);
          else          bq2.push_back(bt);
        end
      end
      frames++;
      if ((stop_c >= s && stop_c <= e) || (cfg != 0 && frames == cfg)) fin = 1;
      else b = e + 1 + gap;
    end
    d = e + LAT + 1;
    dn.c = d; dn.fc = frames % 256; dn.err = err;
    if (d <= lim) begin
      if (gap == 0) dq0.push_back(dn);
      else          dq2.push_back(dn);
    end
  endtask

  beat_t mb0, mb2;
  done_t md0, md2;

  always @(negedge clk) begin
    if (oe0) begin
      if (bq0.size() == 0) chk("u0_spurious_out_en", 1, 0);
      else begin
        mb0 = bq0.pop_front();
        chk("u0_out_cycle", cyc, mb0.c);
        chk("u0_out_first", int'(of0), mb0.first);
        chk("u0_out_last", int'(ol0), mb0.last);
      end
    end
    if (done0) begin
      if (dq0.size() == 0) chk("u0_spurious_done", 1, 0);
      else begin
        md0 = dq0.pop_front();
        chk("u0_done_cycle", cyc, md0.c);
        chk("u0_frame_cnt", int'(fc0), md0.fc);
        chk("u0_err_underrun", int'(err0), md0.err);
        chk("u0_busy_at_done", int'(busy0), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (oe2) begin
      if (bq2.size() == 0) chk("u2_spurious_out_en", 1, 0);
      else begin
        mb2 = bq2.pop_front();
        chk("u2_out_cycle", cyc, mb2.c);
        chk("u2_out_first", int'(of2), mb2.first);
        chk("u2_out_last", int'(ol2), mb2.last);
      end
    end
    if (done2) begin
      if (dq2.size() == 0) chk("u2_spurious_done", 1, 0);
      else begin
        md2 = dq2.pop_front();
        chk("u2_done_cycle", cyc, md2.c);
        chk("u2_frame_cnt", int'(fc2), md2.fc);
        chk("u2_err_underrun", int'(err2), md2.err);
        chk("u2_busy_at_done", int'(busy2), 0);
      end
    end
  end

  task automatic check_quiet(input string tag);
    chk({tag, "_u0_s0_en"}, int'(s0e0), 0);
    chk({tag, "_u0_out_en"}, int'(oe0), 0);
    chk({tag, "_u0_busy"}, int'(busy0), 0);
    chk({tag, "_u0_done"}, int'(done0), 0);
    chk({tag, "_u0_frame_cnt"}, int'(fc0), 0);
    chk({tag, "_u0_err"}, int'(err0), 0);
    chk({tag, "_u2_s0_en"}, int'(s0e2), 0);
    chk({tag, "_u2_out_en"}, int'(oe2), 0);
    chk({tag, "_u2_busy"}, int'(busy2), 0);
    chk({tag, "_u2_done"}, int'(done2), 0);
  endtask

  // Called just after a rising edge with both instances idle; the current
  // cycle is the start cycle. Offsets are relative to it (-1 = none).
  task automatic run(input int cfg, input int stop_rel, input int bad_rel,
                     input int rst_rel, input int ign_rel);
    int s, d0, d2, lim, endc;
    s   = cyc;
    lim = (rst_rel >= 0) ? s + rst_rel : 32'h3fff_ffff;
    model(s, cfg, (stop_rel >= 0) ? s + stop_rel : -1, (bad_rel >= 0) ? s + bad_rel : -1,
          0, lim, d0);
    model(s, cfg, (stop_rel >= 0) ? s + stop_rel : -1, (bad_rel >= 0) ? s + bad_rel : -1,
          2, lim, d2);
    endc = (rst_rel >= 0) ? s + rst_rel + 8 : ((d0 > d2) ? d0 : d2) + 1;
    for (int c = 0; s + c < endc; c++) begin
      start      = (c == 0) || (c == ign_rel);
      stop       = (c == stop_rel);
      in_valid   = (c != bad_rel);
      rst        = (c == rst_rel);
      cfg_frames = (c == 0) ? FW'(cfg) : FW'($urandom);
      if (c == 1) begin
        chk("u0_busy_after_start", int'(busy0), 1);
        chk("u2_busy_after_start", int'(busy2), 1);
        chk("u0_err_cleared", int'(err0), 0);
        chk("u2_err_cleared", int'(err2), 0);
      end
      if (rst_rel >= 0 && c > rst_rel) check_quiet("after_rst");
      @(posedge clk); #1;
    end
    start = 1'b0; stop = 1'b0; in_valid = 1'b1; rst = 1'b0;
    chk("u0_idle_at_end", int'(busy0), 0);
    chk("u2_idle_at_end", int'(busy2), 0);
    chk("u0_beats_left", bq0.size(), 0);
    chk("u2_beats_left", bq2.size(), 0);
    chk("u0_dones_left", dq0.size(), 0);
    chk("u2_dones_left", dq2.size(), 0);
    bq0.delete(); bq2.delete(); dq0.delete(); dq2.delete();
  endtask

  initial begin
    int cfg, sr, br;
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b1; cfg_frames = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    chk("u0_in_ready_reset", int'(ir0), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed cases from the frame-timing scenarios
    run(1, -1, -1, -1, -1);
    run(3, -1, -1, -1, 2);
    run(2, -1, -1, -1, -1);
    run(0, 2, -1, -1, -1);
    run(0, 0, -1, -1, -1);
    run(1, -1, 3, -1, -1);
    chk("u0_err_sticky_idle", int'(err0), 1);
    chk("u2_err_sticky_idle", int'(err2), 1);
    stop = 1'b1;                      // stop while idle must be ignored
    @(posedge clk); #1;
    stop = 1'b0;
    run(1, -1, -1, 3, -1);
    run(1, -1, -1, -1, -1);

    for (int i = 0; i < 30; i++) begin
      cfg = $urandom_range(0, 4);
      if (cfg == 0 || $urandom_range(0, 2) == 0) sr = $urandom_range(0, 20);
      else sr = -1;
      br = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 14) : -1;
      if ($urandom_range(0, 3) == 0) begin
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      run(cfg, sr, br, -1, $urandom_range(1, 4));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
